// File: rtl/mgt_data.sv
// mgt_data - trigger-link framer for two 8b/10b MGT lanes (a, b).
//
// Each 40 MHz bunch crossing spans four clk_160 cycles. Every BX, each lane's
// 56-bit cluster word is sent as four 16-bit words. Word 0 carries a K-char
// frame marker (TTC / overflow status) in its first byte.
// The phase counter, active flag, frame register and output registers are
// held in three copies. Outputs and internal feedback use the 2-of-3 vote.
//
// Ports:
//   clk_160          in   160 MHz clock (single domain)
//   reset            in   synchronous active-high reset
//   gem_data         in   [55:0] lane a, [111:56] lane b
//   overflow_i       in   more than 8 clusters this BX
//   bxn_counter_lsbs in   BX counter LSBs (no functional effect)
//   bc0_i, resync_i  in   TTC flags
//   ready            in   MGT startup done; 0 forces idle
//   trg_tx_data_a/b  out  TXDATA per lane, byte [7:0] sent first
//   trg_tx_isk_a/b   out  TXCHARISK per lane, bit 0 qualifies byte [7:0]
module mgt_data #(
  parameter bit ALLOW_TTC_CHARS = 1'b1,
  parameter bit FRAME_CTRL_TTC  = 1'b1
) (
  input  logic         clk_160,
  input  logic         reset,
  input  logic [111:0] gem_data,
  input  logic         overflow_i,
  input  logic [1:0]   bxn_counter_lsbs,
  input  logic         bc0_i,
  input  logic         resync_i,
  input  logic         ready,
  output logic [15:0]  trg_tx_data_a,
  output logic [15:0]  trg_tx_data_b,
  output logic [1:0]   trg_tx_isk_a,
  output logic [1:0]   trg_tx_isk_b
);

  localparam logic [15:0] IDLE_WORD = 16'h50BC;  // K28.5 + D16.2
  localparam logic [1:0]  IDLE_ISK  = 2'b01;
  localparam bit TTC_A = ALLOW_TTC_CHARS;
  localparam bit TTC_B = ALLOW_TTC_CHARS && FRAME_CTRL_TTC;

  function automatic logic [7:0] frame_ctrl(input logic ttc, input logic bc0,
                                            input logic rsync, input logic ovf);
    if (ttc && rsync)    return 8'h3C;  // K28.1
    else if (ttc && bc0) return 8'h1C;  // K28.0
    else if (ovf)        return 8'h5C;  // K28.2
    else                 return 8'hBC;  // K28.5
  endfunction

  logic w_unused_bxn;
  assign w_unused_bxn = ^bxn_counter_lsbs;

  // Voted state
  logic [1:0]  w_phase;
  logic        w_active;
  logic [47:0] w_frame_a, w_frame_b;

  // Next-state, computed once from the voted state and fed to all copies
  logic [15:0] w_nxt_a, w_nxt_b;
  logic [1:0]  w_nxt_ka, w_nxt_kb;
  logic        w_nxt_active;
  logic [7:0]  w_ctrl_a, w_ctrl_b;

  assign w_ctrl_a = frame_ctrl(TTC_A, bc0_i, resync_i, overflow_i);
  assign w_ctrl_b = frame_ctrl(TTC_B, bc0_i, resync_i, overflow_i);

  // r_active marks that a full frame was started while ready was high; it
  // keeps a late ready rise from producing a partial frame.
  always_comb begin
    w_nxt_a      = IDLE_WORD;
    w_nxt_b      = IDLE_WORD;
    w_nxt_ka     = IDLE_ISK;
    w_nxt_kb     = IDLE_ISK;
    w_nxt_active = w_active;
    if (!ready) begin
      w_nxt_active = 1'b0;
    end else if (w_phase == 2'd0) begin
      w_nxt_a      = {gem_data[7:0], w_ctrl_a};
      w_nxt_b      = {gem_data[63:56], w_ctrl_b};
      w_nxt_active = 1'b1;
    end else if (w_active) begin
      w_nxt_ka = 2'b00;
      w_nxt_kb = 2'b00;
      case (w_phase)
        2'd1: begin
          w_nxt_a = w_frame_a[15:0];
          w_nxt_b = w_frame_b[15:0];
        end
        2'd2: begin
          w_nxt_a = w_frame_a[31:16];
          w_nxt_b = w_frame_b[31:16];
        end
        default: begin
          w_nxt_a = w_frame_a[47:32];
          w_nxt_b = w_frame_b[47:32];
        end
      endcase
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_tmr
    logic [1:0]  r_phase;
    logic        r_active;
    logic [47:0] r_frame_a, r_frame_b;  // g[55:8] of each lane
    logic [15:0] r_out_a, r_out_b;
    logic [1:0]  r_isk_a, r_isk_b;

    always_ff @(posedge clk_160) begin
      if (reset) begin
        r_phase   <= 2'd0;
        r_active  <= 1'b0;
        r_frame_a <= '0;
        r_frame_b <= '0;
        r_out_a   <= IDLE_WORD;
        r_out_b   <= IDLE_WORD;
        r_isk_a   <= IDLE_ISK;
        r_isk_b   <= IDLE_ISK;
      end else begin
        // Increment the voted count so an upset copy heals on the next edge
        r_phase  <= w_phase + 2'd1;
        r_active <= w_nxt_active;
        if (w_phase == 2'd0) begin
          r_frame_a <= gem_data[55:8];
          r_frame_b <= gem_data[111:64];
        end
        r_out_a <= w_nxt_a;
        r_out_b <= w_nxt_b;
        r_isk_a <= w_nxt_ka;
        r_isk_b <= w_nxt_kb;
      end
    end
  end

  // Bitwise 2-of-3 majority
  assign w_phase   = (g_tmr[0].r_phase & g_tmr[1].r_phase) | (g_tmr[0].r_phase & g_tmr[2].r_phase)
                   | (g_tmr[1].r_phase & g_tmr[2].r_phase);
  assign w_active  = (g_tmr[0].r_active & g_tmr[1].r_active) | (g_tmr[0].r_active & g_tmr[2].r_active)
                   | (g_tmr[1].r_active & g_tmr[2].r_active);
  assign w_frame_a = (g_tmr[0].r_frame_a & g_tmr[1].r_frame_a) | (g_tmr[0].r_frame_a & g_tmr[2].r_frame_a)
                   | (g_tmr[1].r_frame_a & g_tmr[2].r_frame_a);
  assign w_frame_b = (g_tmr[0].r_frame_b & g_tmr[1].r_frame_b) | (g_tmr[0].r_frame_b & g_tmr[2].r_frame_b)
                   | (g_tmr[1].r_frame_b & g_tmr[2].r_frame_b);

  assign trg_tx_data_a = (g_tmr[0].r_out_a & g_tmr[1].r_out_a) | (g_tmr[0].r_out_a & g_tmr[2].r_out_a)
                       | (g_tmr[1].r_out_a & g_tmr[2].r_out_a);
  assign trg_tx_data_b = (g_tmr[0].r_out_b & g_tmr[1].r_out_b) | (g_tmr[0].r_out_b & g_tmr[2].r_out_b)
                       | (g_tmr[1].r_out_b & g_tmr[2].r_out_b);
  assign trg_tx_isk_a  = (g_tmr[0].r_isk_a & g_tmr[1].r_isk_a) | (g_tmr[0].r_isk_a & g_tmr[2].r_isk_a)
                       | (g_tmr[1].r_isk_a & g_tmr[2].r_isk_a);
  assign trg_tx_isk_b  = (g_tmr[0].r_isk_b & g_tmr[1].r_isk_b) | (g_tmr[0].r_isk_b & g_tmr[2].r_isk_b)
                       | (g_tmr[1].r_isk_b & g_tmr[2].r_isk_b);

endmodule

// File: tb/tb_mgt_data.sv
// Directed bench for mgt_data: three instances (default params, lane-a-only
// TTC markers, TTC markers disabled) share the same stimulus.
module tb_mgt_data;

  logic clk_160 = 1'b0;
  always #5 clk_160 = ~clk_160;

  logic         reset, overflow_i, bc0_i, resync_i, ready;
  logic [111:0] gem_data;
  logic [1:0]   bxn_counter_lsbs;

  logic [15:0] d_a, d_b, f_a, f_b, n_a, n_b;
  logic [1:0]  k_a, k_b, fk_a, fk_b, nk_a, nk_b;

  mgt_data dut (
    .clk_160(clk_160), .reset(reset), .gem_data(gem_data), .overflow_i(overflow_i),
    .bxn_counter_lsbs(bxn_counter_lsbs), .bc0_i(bc0_i), .resync_i(resync_i), .ready(ready),
    .trg_tx_data_a(d_a), .trg_tx_data_b(d_b), .trg_tx_isk_a(k_a), .trg_tx_isk_b(k_b));

  mgt_data #(.ALLOW_TTC_CHARS(1'b1), .FRAME_CTRL_TTC(1'b0)) dut_f (
    .clk_160(clk_160), .reset(reset), .gem_data(gem_data), .overflow_i(overflow_i),
    .bxn_counter_lsbs(bxn_counter_lsbs), .bc0_i(bc0_i), .resync_i(resync_i), .ready(ready),
    .trg_tx_data_a(f_a), .trg_tx_data_b(f_b), .trg_tx_isk_a(fk_a), .trg_tx_isk_b(fk_b));

  mgt_data #(.ALLOW_TTC_CHARS(1'b0), .FRAME_CTRL_TTC(1'b1)) dut_n (
    .clk_160(clk_160), .reset(reset), .gem_data(gem_data), .overflow_i(overflow_i),
    .bxn_counter_lsbs(bxn_counter_lsbs), .bc0_i(bc0_i), .resync_i(resync_i), .ready(ready),
    .trg_tx_data_a(n_a), .trg_tx_data_b(n_b), .trg_tx_isk_a(nk_a), .trg_tx_isk_b(nk_b));

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [55:0] GA = 56'h0123456789ABCD;
  localparam logic [55:0] GB = 56'hFEDCBA98765432;
  localparam logic [55:0] GC = 56'h13579BDF02468A;
  localparam logic [55:0] GD = 56'hA5A5A5C3C3C3E7;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_160);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "/a"},  d_a, 16'h50BC);
    chk({tag, "/b"},  d_b, 16'h50BC);
    chk({tag, "/ka"}, {14'd0, k_a}, 16'd1);
    chk({tag, "/kb"}, {14'd0, k_b}, 16'd1);
  endtask

  // One BX starting at a negedge whose next posedge is phase 0.
  task automatic run_bx(input string tag, input logic [55:0] ga, input logic [55:0] gb,
                        input logic [7:0] ca, input logic [7:0] cb, input logic [7:0] caf,
                        input logic [7:0] cbf, input logic [7:0] can, input logic [7:0] cbn);
    gem_data = {gb, ga};
    step();
    chk({tag, "/w0a"},  d_a, {ga[7:0], ca});
    chk({tag, "/w0b"},  d_b, {gb[7:0], cb});
    chk({tag, "/k0a"},  {14'd0, k_a}, 16'd1);
    chk({tag, "/k0b"},  {14'd0, k_b}, 16'd1);
    chk({tag, "/f0a"},  f_a, {ga[7:0], caf});
    chk({tag, "/f0b"},  f_b, {gb[7:0], cbf});
    chk({tag, "/n0a"},  n_a, {ga[7:0], can});
    chk({tag, "/n0b"},  n_b, {gb[7:0], cbn});
    step();
    chk({tag, "/w1a"}, d_a, ga[23:8]);
    chk({tag, "/w1b"}, d_b, gb[23:8]);
    chk({tag, "/k1a"}, {14'd0, k_a}, 16'd0);
    step();
    chk({tag, "/w2a"}, d_a, ga[39:24]);
    chk({tag, "/w2b"}, d_b, gb[39:24]);
    step();
    chk({tag, "/w3a"}, d_a, ga[55:40]);
    chk({tag, "/w3b"}, d_b, gb[55:40]);
    chk({tag, "/k3b"}, {14'd0, k_b}, 16'd0);
  endtask

  initial begin
    reset = 1'b1; ready = 1'b0; gem_data = '0; overflow_i = 1'b0;
    bc0_i = 1'b0; resync_i = 1'b0; bxn_counter_lsbs = 2'd0;
    repeat (3) step();
    chk_idle("reset");

    // Next posedge is phase 0; eight idle cycles keep the BX alignment.
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bxn_counter_lsbs = 2'(i);
      step();
      chk_idle("not_ready");
    end

    // First BX with hand-computed words
    ready = 1'b1;
    gem_data = {GB, GA};
    step();
    chk("bx1/w0a", d_a, 16'hCDBC); chk("bx1/k0a", {14'd0, k_a}, 16'd1);
    chk("bx1/w0b", d_b, 16'h32BC);
    step();
    chk("bx1/w1a", d_a, 16'h89AB); chk("bx1/k1a", {14'd0, k_a}, 16'd0);
    chk("bx1/w1b", d_b, 16'h7654);
    step();
    chk("bx1/w2a", d_a, 16'h4567); chk("bx1/w2b", d_b, 16'hBA98);
    step();
    chk("bx1/w3a", d_a, 16'h0123); chk("bx1/w3b", d_b, 16'hFEDC);

    run_bx("bx2", GC, GD, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC);

    bc0_i = 1'b1;
    run_bx("bc0", GA, GC, 8'h1C, 8'h1C, 8'h1C, 8'hBC, 8'hBC, 8'hBC);
    resync_i = 1'b1;
    run_bx("resync", GD, GB, 8'h3C, 8'h3C, 8'h3C, 8'hBC, 8'hBC, 8'hBC);
    resync_i = 1'b0; overflow_i = 1'b1;
    run_bx("bc0_ovf", GB, GA, 8'h1C, 8'h1C, 8'h1C, 8'h5C, 8'h5C, 8'h5C);
    bc0_i = 1'b0;
    run_bx("ovf", GC, GC, 8'h5C, 8'h5C, 8'h5C, 8'h5C, 8'h5C, 8'h5C);
    overflow_i = 1'b0;

    // ready falls before the phase-2 edge, rises before the phase-1 edge
    gem_data = {GB, GA};
    step(); chk("rdy/w0a", d_a, 16'hCDBC);
    step(); chk("rdy/w1a", d_a, 16'h89AB);
    ready = 1'b0;
    step(); chk_idle("rdy_drop_p2");
    step(); chk_idle("rdy_drop_p3");
    step(); chk_idle("rdy_drop_p0");
    ready = 1'b1;
    step(); chk_idle("rdy_rise_p1");
    step(); chk_idle("rdy_rise_p2");
    step(); chk_idle("rdy_rise_p3");
    step(); chk("rdy_rise/w0a", d_a, 16'hCDBC); chk("rdy_rise/w0b", d_b, 16'h32BC);
    step(); chk("rdy_rise/w1a", d_a, 16'h89AB);

    // Reset mid-frame: idle next edge, counter restarts at phase 0
    reset = 1'b1;
    step(); chk_idle("rst_mid");
    reset = 1'b0;
    step(); chk("rst_mid/w0a", d_a, 16'hCDBC);
    step(); chk("rst_mid/w1a", d_a, 16'h89AB);
    step(); chk("rst_mid/w2a", d_a, 16'h4567);
    step(); chk("rst_mid/w3a", d_a, 16'h0123);

    // Single-copy upsets: counter copy 1 and output copy 2
    force dut.g_tmr[1].r_phase = 2'd2;
    force dut.g_tmr[2].r_out_a = 16'hFFFF;
    #1;
    release dut.g_tmr[1].r_phase;
    release dut.g_tmr[2].r_out_a;
    chk("seu/hold_w3a", d_a, 16'h0123);
    step();
    chk("seu/w0a", d_a, 16'hCDBC);
    chk("seu/phase_copy1", {14'd0, dut.g_tmr[1].r_phase}, 16'd1);
    step(); chk("seu/w1a", d_a, 16'h89AB);
    step(); chk("seu/w2a", d_a, 16'h4567);
    step(); chk("seu/w3a", d_a, 16'h0123);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
